// File: rtl/key_filter_multi.sv
// key_filter_multi: N-channel push-button conditioner.
// Each channel synchronises its pin, debounces it on a stable-level basis,
// and emits press/release pulses, a debounced level, a long-press pulse and
// optional auto-repeat pulses. Channels share nothing but clock and reset.

module key_filter_ch #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_pin,
  output logic p_flag,
  output logic r_flag,
  output logic state,
  output logic long_flag,
  output logic rep_flag
);
  // Pin level that means "released"; also the synchroniser reset value.
  localparam logic REL_LVL = (ACTIVE_LOW != 0);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  // hold_cnt serves both the long-press and the repeat interval.
  localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX);
  localparam logic [DW-1:0] DB_TC   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_TC = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_TC  = HW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, PRESSED, LONG_HOLD} st_t;

  logic [1:0]    sync;
  logic          s;
  logic          accept;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  st_t           st;

  // Two-flop synchroniser, reset to the released pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= {2{REL_LVL}};
    else        sync <= {sync[0], key_pin};
  end

  // s = 1 means pressed regardless of pin polarity.
  assign s      = sync[1] ^ REL_LVL;
  // A level change is accepted once s has differed for DEBOUNCE_CYCLES cycles.
  assign accept = (s != state) && (db_cnt == DB_TC);

  // Stable-level debounce: count while s disagrees, restart on any agreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      state  <= 1'b0;
    end else if (s == state) begin
      db_cnt <= '0;
    end else if (accept) begin
      db_cnt <= '0;
      state  <= ~state;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Hold FSM with registered pulses; release beats a same-cycle terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= RELEASED;
      hold_cnt  <= '0;
      p_flag    <= 1'b0;
      r_flag    <= 1'b0;
      long_flag <= 1'b0;
      rep_flag  <= 1'b0;
    end else begin
      p_flag    <= 1'b0;
      r_flag    <= 1'b0;
      long_flag <= 1'b0;
      rep_flag  <= 1'b0;
      case (st)
        RELEASED: begin
          if (accept && !state) begin
            st       <= PRESSED;
            hold_cnt <= '0;
            p_flag   <= 1'b1;
          end
        end
        PRESSED: begin
          if (accept && state) begin
            st       <= RELEASED;
            hold_cnt <= '0;
            r_flag   <= 1'b1;
          end else if (hold_cnt == LONG_TC) begin
            st        <= LONG_HOLD;
            hold_cnt  <= '0;
            long_flag <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONG_HOLD: begin
          if (accept && state) begin
            st       <= RELEASED;
            hold_cnt <= '0;
            r_flag   <= 1'b1;
          end else if (REPEAT_EN == 0) begin
            hold_cnt <= '0;
          end else if (hold_cnt == REP_TC) begin
            hold_cnt <= '0;
            rep_flag <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          st       <= RELEASED;
          hold_cnt <= '0;
        end
      endcase
    end
  end
endmodule

module key_filter_multi #(
  parameter int KEY_NUM         = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_p_flag,
  output logic [KEY_NUM-1:0] key_r_flag,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_long_flag,
  output logic [KEY_NUM-1:0] key_rep_flag,
  output logic               key_any
);
  // One independent conditioner per key pin.
  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_filter_ch #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_EN)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_pin   (key_in[i]),
      .p_flag    (key_p_flag[i]),
      .r_flag    (key_r_flag[i]),
      .state     (key_state[i]),
      .long_flag (key_long_flag[i]),
      .rep_flag  (key_rep_flag[i])
    );
  end

  assign key_any = |key_state;
endmodule

// File: tb/tb_key_filter_multi.sv
// Bench for key_filter_multi: directed key patterns, expected pulses queued at
// drive time with their due cycle, checked every cycle on the falling edge.

module tb_key_filter_multi;
  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 8;
  localparam int LAT = 2 + DEB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] key_in;
  logic [N-1:0] key_p_flag, key_r_flag, key_state, key_long_flag, key_rep_flag;
  logic         key_any;

  key_filter_multi #(
    .KEY_NUM(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_p_flag(key_p_flag), .key_r_flag(key_r_flag), .key_state(key_state),
    .key_long_flag(key_long_flag), .key_rep_flag(key_rep_flag), .key_any(key_any)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 press, 1 release, 2 long, 3 repeat
  typedef struct {int due; int ch; int kind;} ev_t;
  ev_t q[$];

  int n_assert = 0;
  int n_fail   = 0;
  logic [N-1:0] exp_state = '0;

  task automatic push(input int due, input int ch, input int kind);
    ev_t e;
    e.due = due; e.ch = ch; e.kind = kind;
    q.push_back(e);
  endtask

  // Expected events for a pin held pressed from cycle c for len cycles.
  task automatic push_hold(input int ch, input int c, input int len);
    int rel;
    rel = c + len + LAT;
    push(c + LAT, ch, 0);
    push(rel, ch, 1);
    if (c + LAT + LNG < rel) push(c + LAT + LNG, ch, 2);
    for (int t = c + LAT + LNG + REP; t < rel; t += REP) push(t, ch, 3);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Per-cycle scoreboard check of every output.
  always @(negedge clk) begin
    logic [N-1:0] ep, er, el, erp;
    ep = '0; er = '0; el = '0; erp = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        case (q[i].kind)
          0: ep[q[i].ch] = 1'b1;
          1: er[q[i].ch] = 1'b1;
          2: el[q[i].ch] = 1'b1;
          default: erp[q[i].ch] = 1'b1;
        endcase
        q.delete(i);
      end
    end
    if (!rst_n) exp_state = '0;
    else exp_state = (exp_state | ep) & ~er;
    n_assert++;
    assert (key_p_flag === ep) else begin
      n_fail++; $error("FAIL p_flag cyc=%0d got=%b exp=%b", cyc, key_p_flag, ep);
    end
    n_assert++;
    assert (key_r_flag === er) else begin
      n_fail++; $error("FAIL r_flag cyc=%0d got=%b exp=%b", cyc, key_r_flag, er);
    end
    n_assert++;
    assert (key_long_flag === el) else begin
      n_fail++; $error("FAIL long_flag cyc=%0d got=%b exp=%b", cyc, key_long_flag, el);
    end
    n_assert++;
    assert (key_rep_flag === erp) else begin
      n_fail++; $error("FAIL rep_flag cyc=%0d got=%b exp=%b", cyc, key_rep_flag, erp);
    end
    n_assert++;
    assert (key_state === exp_state) else begin
      n_fail++; $error("FAIL key_state cyc=%0d got=%b exp=%b", cyc, key_state, exp_state);
    end
    n_assert++;
    assert (key_any === (|exp_state)) else begin
      n_fail++; $error("FAIL key_any cyc=%0d got=%b exp=%b", cyc, key_any, |exp_state);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    rst_n  = 1'b0;
    key_in = '1;
    step(3);
    rst_n = 1'b1;
    step(5);

    // Clean press on key 0.
    c = cyc; key_in[0] = 1'b0; push_hold(0, c, 12);
    step(12); key_in[0] = 1'b1;
    step(10);

    // Bounce on key 1: toggles every 2 cycles, never stable long enough.
    for (int k = 0; k < 15; k++) begin
      key_in[1] = ~key_in[1];
      step(2);
    end
    key_in[1] = 1'b1;
    step(10);

    // Long press with repeats on key 2; release collides with a repeat count.
    c = cyc; key_in[2] = 1'b0; push_hold(2, c, 60);
    step(60); key_in[2] = 1'b1;
    step(10);

    // Keys 0 and 3 pressed together, released 10 cycles apart.
    c = cyc; key_in[0] = 1'b0; key_in[3] = 1'b0;
    push_hold(0, c, 5); push_hold(3, c, 15);
    step(5);  key_in[0] = 1'b1;
    step(10); key_in[3] = 1'b1;
    step(10);

    // Release acceptance lands on the long-press terminal count.
    c = cyc; key_in[1] = 1'b0; push_hold(1, c, LNG);
    step(LNG); key_in[1] = 1'b1;
    step(10);

    // Reset while key 2 is in long hold, pin kept low across reset.
    c = cyc; key_in[2] = 1'b0;
    push(c + LAT, 2, 0); push(c + LAT + LNG, 2, 2); push(c + LAT + LNG + REP, 2, 3);
    step(LAT + LNG + REP + 2);
    n_assert++;
    assert (q.size() === 0) else begin
      n_fail++; $error("FAIL pre_reset_queue got=%0d exp=0", q.size());
    end
    rst_n = 1'b0;
    #1;
    n_assert++;
    assert ({key_p_flag, key_r_flag, key_state, key_long_flag, key_rep_flag, key_any} === '0)
    else begin
      n_fail++; $error("FAIL async_reset got=%b exp=0",
        {key_p_flag, key_r_flag, key_state, key_long_flag, key_rep_flag, key_any});
    end
    step(2);
    rst_n = 1'b1;
    c = cyc; push_hold(2, c, 25);
    step(25); key_in[2] = 1'b1;
    step(12);

    n_assert++;
    assert (q.size() === 0) else begin
      n_fail++; $error("FAIL final_queue got=%0d exp=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
